// File: rtl/cci_mpf_shim_buffer_fiu_c0rx.sv
// ---------------------------------------------------------------------------
// cci_mpf_shim_buffer_fiu_c0rx
//
// Credit-managed read-response buffer on the FIU side of a shim. c0Rx has no
// back pressure, so every line requested on c0Tx reserves a slot here before
// the request leaves. Returning responses are parked in a LUTRAM FIFO and the
// downstream consumer drains them at its own pace. The almost-full signal
// toward the requester is derived from the remaining free credits. That keeps
// the THRESHOLD requests that may still be in flight after assertion covered.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset, sync release
//   c0Tx_req        a read request is issued this cycle
//   c0Tx_cl_len     line count minus 1 of that request
//   c0TxAlmFull     registered almost-full toward the requester
//   c0Rx_rdValid    read-response line valid (MMIO/write responses removed)
//   c0Rx_data       response header and data
//   first           head of FIFO, valid when notEmpty
//   notEmpty        at least one response is available
//   deq_en          consume the head (ignored when notEmpty is low)
//   credits         free-line credit count
//   error           sticky: [0] credit underflow, [1] response dropped (full)
//
// Handshake: the consumer may pulse deq_en in any cycle; a dequeue happens
// only in a cycle where notEmpty is high, and first/notEmpty update on the
// following clock edge. There is no ready on c0Rx: a response presented with
// c0Rx_rdValid is taken in that cycle or dropped (with error[1]) if no slot.
// ---------------------------------------------------------------------------
module cci_mpf_shim_buffer_fiu_c0rx #(
  parameter int THRESHOLD       = 1,
  parameter int MAX_LINES       = 4,
  parameter int N_ENTRIES       = MAX_LINES * (THRESHOLD + 1) + 8,
  parameter int N_DATA_BITS     = 28 + 512,
  parameter int REGISTER_OUTPUT = 0,
  // Enables the simulation-only protocol checks below.
  parameter int SIM_CHECKS      = 1,
  localparam int CW             = $clog2(N_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c0Tx_req,
  input  logic [1:0]             c0Tx_cl_len,
  output logic                   c0TxAlmFull,
  input  logic                   c0Rx_rdValid,
  input  logic [N_DATA_BITS-1:0] c0Rx_data,
  output logic [N_DATA_BITS-1:0] first,
  output logic                   notEmpty,
  input  logic                   deq_en,
  output logic [CW-1:0]          credits,
  output logic [1:0]             error
);

  localparam int AF_LINES = MAX_LINES * (THRESHOLD + 1);
  localparam int PW       = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  // Extra headroom so credit arithmetic can go "negative" without wrapping.
  localparam int EW       = CW + 3;

  generate
    if (N_ENTRIES < AF_LINES) begin : g_size_check
      $error("N_ENTRIES must be >= MAX_LINES*(THRESHOLD+1)");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q;

  logic fifo_ne;
  logic fifo_full;
  logic fifo_pop;
  logic fifo_push;
  logic deq_accept;
  logic drop;

  assign fifo_ne   = (count_q != '0);
  assign fifo_full = (count_q == CW'(N_ENTRIES));

  // A full FIFO may still accept a line when the head leaves in the same
  // cycle: the write lands on the slot being vacated.
  assign fifo_push = !reset && c0Rx_rdValid && (!fifo_full || fifo_pop);
  assign drop      = c0Rx_rdValid && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem[wr_ptr_q] <= c0Rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(N_ENTRIES - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(N_ENTRIES - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output stage: direct LUTRAM read, or one skid register
  // -------------------------------------------------------------------------
  generate
    if (REGISTER_OUTPUT != 0) begin : g_reg_out
      logic                   out_valid_q;
      logic [N_DATA_BITS-1:0] out_data_q;

      // Refill the output register whenever it is empty or being consumed.
      assign deq_accept = deq_en && out_valid_q;
      assign fifo_pop   = fifo_ne && (!out_valid_q || deq_en);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_valid_q <= 1'b0;
        end else if (fifo_pop) begin
          out_valid_q <= 1'b1;
        end else if (deq_accept) begin
          out_valid_q <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (fifo_pop) begin
          out_data_q <= mem[rd_ptr_q];
        end
      end

      assign notEmpty = out_valid_q;
      assign first    = out_data_q;
    end else begin : g_direct_out
      assign deq_accept = deq_en && fifo_ne;
      assign fifo_pop   = deq_accept;
      assign notEmpty   = fifo_ne;
      assign first      = mem[rd_ptr_q];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Credits, almost full and sticky errors
  // -------------------------------------------------------------------------
  logic [CW-1:0] credits_q;
  logic          alm_full_q;
  logic [1:0]    err_q;

  logic [EW-1:0] req_lines;
  logic [EW-1:0] avail;
  logic          underflow;
  logic [CW-1:0] credits_next;

  always_comb begin
    req_lines    = '0;
    avail        = '0;
    underflow    = 1'b0;
    credits_next = credits_q;
    if (c0Tx_req) begin
      req_lines = EW'(c0Tx_cl_len) + EW'(1);
    end
    // Returned credit and consumed credits apply together, no priority.
    avail = EW'(credits_q) + EW'(deq_accept);
    if (avail < req_lines) begin
      underflow    = 1'b1;
      credits_next = '0;
    end else begin
      credits_next = CW'(avail - req_lines);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q  <= CW'(N_ENTRIES);
      alm_full_q <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      credits_q  <= credits_next;
      alm_full_q <= (int'(credits_next) < AF_LINES);
      if (underflow) begin
        err_q[0] <= 1'b1;
      end
      if (drop) begin
        err_q[1] <= 1'b1;
      end
    end
  end

  assign credits     = credits_q;
  assign c0TxAlmFull = alm_full_q;
  assign error       = err_q;

  // -------------------------------------------------------------------------
  // Simulation-only protocol checks
  // -------------------------------------------------------------------------
  always @(posedge clk) begin
    if (!reset && (SIM_CHECKS != 0)) begin
      assert (!underflow)
        else $warning("c0rx buffer: credit underflow");
      assert (!drop)
        else $warning("c0rx buffer: response arrived with FIFO full");
      assert (!(deq_en && !notEmpty))
        else $warning("c0rx buffer: deq_en while empty");
    end
  end

endmodule

// File: doc/cci_mpf_shim_buffer_fiu_c0rx.md
Name: cci_mpf_shim_buffer_fiu_c0rx

Overview:
- Credit-managed read-response buffer on the FIU side of a shim; the opposite direction to the AFU-side Tx request buffers.
- CCI c0Rx has no back pressure, so this block:
  - reserves buffer space for every read line requested on c0Tx,
  - stores the returning read responses in a LUTRAM FIFO,
  - lets the downstream consumer dequeue them at its own pace.
- c0TxAlmFull toward the requester is derived from the free credits, so every outstanding line always has a slot.

Parameters:
- THRESHOLD, CCI_TX_ALMOST_FULL_THRESHOLD: number of requests the requester may still issue after it sees almost full.
- MAX_LINES, 4: maximum lines per read request (cl_len + 1).
- N_ENTRIES, MAX_LINES*(THRESHOLD+1)+8: response FIFO depth in lines. Must be >= MAX_LINES*(THRESHOLD+1); elaboration error otherwise.
- N_DATA_BITS, CCI_C0RX_MEMHDR_WIDTH+CCI_CLDATA_WIDTH: width of a stored response (header and data).
- REGISTER_OUTPUT, 0: if nonzero, FIFO output passes through a skid register (adds 1 cycle).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- c0Tx_req  in  1  a read request is issued to the FIU this cycle
- c0Tx_cl_len  in  2  line count minus 1 of that request; only meaningful with c0Tx_req
- c0TxAlmFull  out  1  almost full toward the requester (registered)
- c0Rx_rdValid  in  1  read-response line valid. Upstream filters out MMIO and write responses.
- c0Rx_data  in  N_DATA_BITS  response header and data
- first  out  N_DATA_BITS  head of FIFO; valid when notEmpty
- notEmpty  out  1  FIFO holds at least one response
- deq_en  in  1  consume head; legal only when notEmpty
- credits  out  $clog2(N_ENTRIES+1)  free-line credit count (debug and verification)
- error  out  2  sticky: bit0 = credit underflow, bit1 = response arrived with FIFO full

Behaviour:
- Reset (async assert, sync release), all outputs:
  - credits = N_ENTRIES
  - FIFO empty: notEmpty = 0, first is don't-care
  - c0TxAlmFull = 0
  - error = 0
  - Responses arriving while reset is high are dropped.
- Credit counter (registered), per cycle:
  - credits_next = credits − (c0Tx_req ? c0Tx_cl_len+1 : 0) + (deq_en && notEmpty ? 1 : 0)
  - Request and dequeue in the same cycle both apply; there is no priority.
  - Credits are consumed at request issue and returned at dequeue, not at response arrival.
- Almost full:
  - c0TxAlmFull <= (credits_next < MAX_LINES*(THRESHOLD+1)).
  - Registered, so it is visible the cycle after the crossing.
  - The sizing guarantees that THRESHOLD further max-length requests after assertion never underflow the credits.
  - Deasserts the cycle after credits_next reaches >= MAX_LINES*(THRESHOLD+1).
- Underflow:
  - If the decrement would take credits below 0, set error[0], saturate credits at 0 and update nothing else.
  - Simulation assertion fires.
- FIFO:
  - Enqueue c0Rx_data when c0Rx_rdValid.
  - Ordering is arrival order; no reordering or header inspection.
  - Enqueue and dequeue in the same cycle are both allowed at any occupancy, including full (net occupancy unchanged).
  - Enqueue when full without a simultaneous dequeue: data dropped, error[1] set, simulation assertion fires.
- Latency:
  - Enqueue at cycle t gives notEmpty = 1 and first = data at t+1.
  - With REGISTER_OUTPUT != 0, this is t+2.
  - No bypass path.
- deq_en with notEmpty = 0 is ignored: no credit return. Simulation assertion fires.
- FIFO pointers wrap modulo N_ENTRIES.
  - The occupancy counter distinguishes full from empty.
  - Invariant: occupancy + credits + outstanding lines == N_ENTRIES.
- Reset mid-operation:
  - Everything returns to its reset values.
  - The parent must not assert reset with reads outstanding at the FIU.

Test Plan:
- Reset release, THRESHOLD=1, MAX_LINES=4, N_ENTRIES=16 → credits=16, c0TxAlmFull=0, notEmpty=0, error=0.
- Issue 2 requests with cl_len=3, then 1 with cl_len=0 (credits 16→12→8→7) → c0TxAlmFull=1 the cycle after credits reach 7 (<8); no error.
- From credits=7, issue 1 more cl_len=3 request → credits=3 and error=0. Return 9 lines, enqueue at t, dequeue 9 at 1/cycle → first valid at t+1 in arrival order, credits climb to 12, c0TxAlmFull deasserts the cycle after credits ≥8.
- Same-cycle c0Tx_req(cl_len=1) and deq_en with credits=10 → credits=9. Same-cycle enqueue and dequeue while FIFO is full → occupancy unchanged, error[1]=0.
- Fill FIFO to 16 without dequeue, then one extra rdValid → error[1]=1 and stays set. A cl_len=3 request at credits=2 → error[0]=1, credits=0.
- Assert reset asynchronously mid-burst with 5 entries queued → same cycle: notEmpty=0, credits=16, c0TxAlmFull=0, error=0.
